// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters (round-robin or fixed priority).
// Accept in cycle N gives a response in cycle N+2; one op in flight, held until the owner takes it.
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter bit FAIR = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic [11:0]       i_req_ctrl,
  input  logic [2*XLEN-1:0] i_req_op1,
  input  logic [2*XLEN-1:0] i_req_op2,
  output logic [1:0]        o_rsp_valid,
  input  logic [1:0]        i_rsp_ready,
  output logic [XLEN-1:0]   o_rsp_result,
  output logic              o_rsp_eq,
  output logic              o_rsp_slt,
  output logic [2:0]        o_alu_opsel,
  output logic              o_alu_sub,
  output logic              o_alu_unsigned,
  output logic              o_alu_arith,
  output logic [XLEN-1:0]   o_alu_op1,
  output logic [XLEN-1:0]   o_alu_op2,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic              i_alu_eq,
  input  logic              i_alu_slt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_prio;
  logic              r_owner;
  logic [5:0]        r_ctrl;
  logic [XLEN-1:0]   r_op1;
  logic [XLEN-1:0]   r_op2;
  logic [XLEN-1:0]   r_res;
  logic              r_eq;
  logic              r_slt;
  logic              w_accept;
  logic              w_sel;
  logic              w_rsp_hs;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (w_rsp_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant is a function of the current valids only; the pointer breaks ties when both ask.
  always_comb begin
    o_req_ready = 2'b00;
    o_rsp_valid = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid == 2'b11) o_req_ready = (FAIR && r_prio) ? 2'b10 : 2'b01;
        else                      o_req_ready = i_req_valid;
      end
      S_RESP:  o_rsp_valid = r_owner ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign w_accept = |o_req_ready;
  assign w_sel    = o_req_ready[1];
  assign w_rsp_hs = (r_state == S_RESP) && i_rsp_ready[r_owner];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
      r_ctrl  <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_res   <= '0;
      r_eq    <= 1'b0;
      r_slt   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner <= w_sel;
        r_ctrl  <= w_sel ? i_req_ctrl[11:6] : i_req_ctrl[5:0];
        r_op1   <= w_sel ? i_req_op1[2*XLEN-1:XLEN] : i_req_op1[XLEN-1:0];
        r_op2   <= w_sel ? i_req_op2[2*XLEN-1:XLEN] : i_req_op2[XLEN-1:0];
        if (FAIR) r_prio <= ~w_sel;
      end
      if (r_state == S_EXEC) begin
        r_res <= i_alu_result;
        r_eq  <= i_alu_eq;
        r_slt <= i_alu_slt;
      end
    end
  end

  assign o_alu_opsel    = r_ctrl[5:3];
  assign o_alu_sub      = r_ctrl[2];
  assign o_alu_unsigned = r_ctrl[1];
  assign o_alu_arith    = r_ctrl[0];
  assign o_alu_op1      = r_op1;
  assign o_alu_op2      = r_op2;
  assign o_rsp_result   = r_res;
  assign o_rsp_eq       = r_eq;
  assign o_rsp_slt      = r_slt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one round-robin and one fixed-priority instance share stimulus,
// each driving a behavioural ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [11:0] req_ctrl;
  logic [63:0] req_op1;
  logic [63:0] req_op2;

  logic [1:0]  ready_a, rsp_valid_a, ready_b, rsp_valid_b;
  logic [31:0] res_a, res_b, aop1_a, aop2_a, aop1_b, aop2_b, alu_res_a, alu_res_b;
  logic        eq_a, slt_a, eq_b, slt_b, alu_eq_a, alu_slt_a, alu_eq_b, alu_slt_b;
  logic [2:0]  opsel_a, opsel_b;
  logic        sub_a, uns_a, arith_a, sub_b, uns_b, arith_b;

  int n_checks = 0;
  int n_fail   = 0;

  // ALU: ctrl = {opsel, sub, unsigned, arith}; returns {eq, slt, result}
  function automatic logic [33:0] alu_ref(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        lt;
    lt = c[1] ? (a < b) : ($signed(a) < $signed(b));
    case (c[5:3])
      3'd0:    r = c[2] ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2,
      3'd3:    r = {31'b0, lt};
      3'd4:    r = a ^ b;
      3'd5: begin
        if (c[0]) r = $signed(a) >>> b[4:0];
        else      r = a >> b[4:0];
      end
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return {a == b, lt, r};
  endfunction

  assign {alu_eq_a, alu_slt_a, alu_res_a} = alu_ref({opsel_a, sub_a, uns_a, arith_a}, aop1_a, aop2_a);
  assign {alu_eq_b, alu_slt_b, alu_res_b} = alu_ref({opsel_b, sub_b, uns_b, arith_b}, aop1_b, aop2_b);

  alu_arbiter #(.XLEN(32), .FAIR(1'b1)) u_fair (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready_a),
    .i_req_ctrl(req_ctrl), .i_req_op1(req_op1), .i_req_op2(req_op2),
    .o_rsp_valid(rsp_valid_a), .i_rsp_ready(rsp_ready), .o_rsp_result(res_a),
    .o_rsp_eq(eq_a), .o_rsp_slt(slt_a), .o_alu_opsel(opsel_a), .o_alu_sub(sub_a),
    .o_alu_unsigned(uns_a), .o_alu_arith(arith_a), .o_alu_op1(aop1_a), .o_alu_op2(aop2_a),
    .i_alu_result(alu_res_a), .i_alu_eq(alu_eq_a), .i_alu_slt(alu_slt_a));

  alu_arbiter #(.XLEN(32), .FAIR(1'b0)) u_fixed (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready_b),
    .i_req_ctrl(req_ctrl), .i_req_op1(req_op1), .i_req_op2(req_op2),
    .o_rsp_valid(rsp_valid_b), .i_rsp_ready(rsp_ready), .o_rsp_result(res_b),
    .o_rsp_eq(eq_b), .o_rsp_slt(slt_b), .o_alu_opsel(opsel_b), .o_alu_sub(sub_b),
    .o_alu_unsigned(uns_b), .o_alu_arith(arith_b), .o_alu_op1(aop1_b), .o_alu_op2(aop2_b),
    .i_alu_result(alu_res_b), .i_alu_eq(alu_eq_b), .i_alu_slt(alu_slt_b));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_ctrl = '0; req_op1 = '0; req_op2 = '0;
    tick(); tick();
    n_checks++; if (ready_a !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", ready_a); end
    n_checks++; if (rsp_valid_a !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_a); end
    n_checks++; if ({eq_a, slt_a, res_a} !== 34'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", {eq_a, slt_a, res_a}); end
    n_checks++; if ({opsel_a, sub_a, uns_a, arith_a, aop1_a, aop2_a} !== 70'd0) begin
      n_fail++; $display("FAIL reset_alu_out: got %h want 0", {opsel_a, sub_a, uns_a, arith_a, aop1_a, aop2_a}); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_ctrl = 12'd0; req_op1 = {32'd0, 32'd100}; req_op2 = {32'd0, 32'd50}; req_valid = 2'b01;
    #1;
    n_checks++; if (ready_a !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", ready_a); end
    tick(); req_valid = 2'b00; #1;
    n_checks++; if (rsp_valid_a !== 2'b00) begin n_fail++; $display("FAIL single_exec_valid: got %b want 00", rsp_valid_a); end
    n_checks++; if (aop1_a !== 32'd100 || aop2_a !== 32'd50) begin
      n_fail++; $display("FAIL single_alu_ops: got %0d,%0d want 100,50", aop1_a, aop2_a); end
    tick();
    n_checks++; if (rsp_valid_a !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid_a); end
    n_checks++; if ({eq_a, slt_a, res_a} !== {1'b0, 1'b0, 32'd150}) begin
      n_fail++; $display("FAIL single_result: got %h want %h", {eq_a, slt_a, res_a}, {1'b0, 1'b0, 32'd150}); end
    rsp_ready = 2'b01; tick(); rsp_ready = 2'b00;
    n_checks++; if (rsp_valid_a !== 2'b00) begin n_fail++; $display("FAIL single_after_hs: got %b want 00", rsp_valid_a); end
  endtask

  task automatic test_dual();
    do_reset();
    req_ctrl = {6'b100000, 6'b000100};
    req_op1 = {32'hAAAAAAAA, 32'd50}; req_op2 = {32'h55555555, 32'd100}; req_valid = 2'b11;
    #1;
    n_checks++; if (ready_a !== 2'b01 || ready_b !== 2'b01) begin
      n_fail++; $display("FAIL dual_first_grant: got %b/%b want 01/01", ready_a, ready_b); end
    tick(); req_valid = 2'b10; tick();
    n_checks++; if (rsp_valid_a !== 2'b01) begin n_fail++; $display("FAIL dual_rsp0_valid: got %b want 01", rsp_valid_a); end
    n_checks++; if (res_a !== 32'hFFFFFFCE || slt_a !== 1'b1) begin
      n_fail++; $display("FAIL dual_rsp0_data: got %h slt %b want FFFFFFCE slt 1", res_a, slt_a); end
    rsp_ready = 2'b11; tick(); rsp_ready = 2'b00; #1;
    n_checks++; if (ready_a !== 2'b10) begin n_fail++; $display("FAIL dual_second_grant: got %b want 10", ready_a); end
    tick(); req_valid = 2'b00; tick();
    n_checks++; if (rsp_valid_a !== 2'b10 || res_a !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL dual_rsp1: got %b %h want 10 FFFFFFFF", rsp_valid_a, res_a); end
    rsp_ready = 2'b11; tick(); rsp_ready = 2'b00;
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_a;
    logic [33:0] want_a, want_b;
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      req_ctrl = 12'($urandom); req_op1 = {$urandom, $urandom}; req_op2 = {$urandom, $urandom};
      exp_a  = (i % 2 == 0) ? 2'b01 : 2'b10;
      want_a = exp_a[1] ? alu_ref(req_ctrl[11:6], req_op1[63:32], req_op2[63:32])
                        : alu_ref(req_ctrl[5:0], req_op1[31:0], req_op2[31:0]);
      want_b = alu_ref(req_ctrl[5:0], req_op1[31:0], req_op2[31:0]);
      #1;
      n_checks++; if (ready_a !== exp_a) begin n_fail++; $display("FAIL fair_grant_%0d: got %b want %b", i, ready_a, exp_a); end
      n_checks++; if (ready_b !== 2'b01) begin n_fail++; $display("FAIL fixed_grant_%0d: got %b want 01", i, ready_b); end
      tick(); tick();
      n_checks++; if (rsp_valid_a !== exp_a || {eq_a, slt_a, res_a} !== want_a) begin
        n_fail++; $display("FAIL fair_rsp_%0d: got %b %h want %b %h", i, rsp_valid_a, {eq_a, slt_a, res_a}, exp_a, want_a); end
      n_checks++; if (rsp_valid_b !== 2'b01 || {eq_b, slt_b, res_b} !== want_b) begin
        n_fail++; $display("FAIL fixed_rsp_%0d: got %b %h want 01 %h", i, rsp_valid_b, {eq_b, slt_b, res_b}, want_b); end
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
  endtask

  task automatic test_hold();
    req_ctrl = {6'b101001, 6'd0};
    req_op1 = {32'h80000000, 32'd0}; req_op2 = {32'd4, 32'd0};
    req_valid = 2'b10; rsp_ready = 2'b00;
    #1;
    n_checks++; if (ready_a !== 2'b10) begin n_fail++; $display("FAIL hold_grant: got %b want 10", ready_a); end
    tick(); req_valid = 2'b01; #1;
    n_checks++; if (ready_a !== 2'b00) begin n_fail++; $display("FAIL hold_exec_ready: got %b want 00", ready_a); end
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (rsp_valid_a !== 2'b10 || res_a !== 32'hF8000000 || ready_a !== 2'b00) begin
        n_fail++; $display("FAIL hold_cycle_%0d: got v=%b r=%h rdy=%b want 10 F8000000 00", k, rsp_valid_a, res_a, ready_a); end
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b10; tick(); rsp_ready = 2'b00;
    n_checks++; if (rsp_valid_a !== 2'b00 || res_a !== 32'hF8000000) begin
      n_fail++; $display("FAIL hold_release: got %b %h want 00 F8000000", rsp_valid_a, res_a); end
  endtask

  task automatic test_reset_exec();
    req_ctrl = 12'd0; req_op1 = {32'd0, 32'd7}; req_op2 = {32'd0, 32'd8}; req_valid = 2'b01;
    tick();
    req_valid = 2'b00; rst = 1'b1;
    tick();
    n_checks++; if (ready_a !== 2'b00 || rsp_valid_a !== 2'b00) begin
      n_fail++; $display("FAIL rexec_hs: got %b %b want 00 00", ready_a, rsp_valid_a); end
    n_checks++; if ({eq_a, slt_a, res_a} !== 34'd0) begin
      n_fail++; $display("FAIL rexec_rsp_data: got %h want 0", {eq_a, slt_a, res_a}); end
    n_checks++; if ({opsel_a, sub_a, uns_a, arith_a, aop1_a, aop2_a} !== 70'd0) begin
      n_fail++; $display("FAIL rexec_alu_out: got %h want 0", {opsel_a, sub_a, uns_a, arith_a, aop1_a, aop2_a}); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (rsp_valid_a !== 2'b00) begin n_fail++; $display("FAIL rexec_no_rsp_%0d: got %b want 00", k, rsp_valid_a); end
    end
    req_valid = 2'b11; #1;
    n_checks++; if (ready_a !== 2'b01) begin n_fail++; $display("FAIL rexec_prio: got %b want 01", ready_a); end
    req_valid = 2'b00;
    tick();
    n_checks++; if (rsp_valid_a !== 2'b00) begin n_fail++; $display("FAIL withdraw_state: got %b want 00", rsp_valid_a); end
    req_valid = 2'b11; #1;
    n_checks++; if (ready_a !== 2'b01) begin n_fail++; $display("FAIL withdraw_prio: got %b want 01", ready_a); end
    tick(); req_valid = 2'b00; tick();
    n_checks++; if (rsp_valid_a !== 2'b01 || res_a !== 32'd15) begin
      n_fail++; $display("FAIL withdraw_then_op: got %b %0d want 01 15", rsp_valid_a, res_a); end
    rsp_ready = 2'b11; tick(); rsp_ready = 2'b00;
  endtask

  task automatic test_wrong_ready();
    req_ctrl = {6'd0, 6'b111000}; req_op1 = {32'd0, 32'hF0F0}; req_op2 = {32'd0, 32'h0FF0}; req_valid = 2'b01;
    tick(); req_valid = 2'b00; tick();
    rsp_ready = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (rsp_valid_a !== 2'b01 || res_a !== 32'h00F0) begin
        n_fail++; $display("FAIL wrong_ready_%0d: got %b %h want 01 000000F0", k, rsp_valid_a, res_a); end
      tick();
    end
    rsp_ready = 2'b01; tick(); rsp_ready = 2'b00;
    n_checks++; if (rsp_valid_a !== 2'b00) begin n_fail++; $display("FAIL wrong_ready_release: got %b want 00", rsp_valid_a); end
  endtask

  task automatic test_random();
    logic        prio_m;
    logic [1:0]  v, exp_a, exp_b;
    logic [33:0] want_a, want_b;
    int          d;
    do_reset();
    prio_m = 1'b0;
    for (int n = 0; n < 40; n++) begin
      v = 2'($urandom_range(0, 3));
      req_ctrl = 12'($urandom); req_op1 = {$urandom, $urandom}; req_op2 = {$urandom, $urandom};
      req_valid = v;
      exp_a = (v == 2'b11) ? (prio_m ? 2'b10 : 2'b01) : v;
      exp_b = (v == 2'b11) ? 2'b01 : v;
      #1;
      n_checks++; if (ready_a !== exp_a || ready_b !== exp_b) begin
        n_fail++; $display("FAIL rand_grant_%0d: got %b/%b want %b/%b", n, ready_a, ready_b, exp_a, exp_b); end
      if (exp_a != 2'b00) begin
        want_a = exp_a[1] ? alu_ref(req_ctrl[11:6], req_op1[63:32], req_op2[63:32])
                          : alu_ref(req_ctrl[5:0], req_op1[31:0], req_op2[31:0]);
        want_b = exp_b[1] ? alu_ref(req_ctrl[11:6], req_op1[63:32], req_op2[63:32])
                          : alu_ref(req_ctrl[5:0], req_op1[31:0], req_op2[31:0]);
        prio_m = exp_a[0];
        tick();
        req_valid = 2'($urandom); #1;
        n_checks++; if (ready_a !== 2'b00 || ready_b !== 2'b00) begin
          n_fail++; $display("FAIL rand_busy_ready_%0d: got %b/%b want 00/00", n, ready_a, ready_b); end
        tick();
        d = $urandom_range(0, 3);
        for (int j = 0; j <= d; j++) begin
          n_checks++; if (rsp_valid_a !== exp_a || {eq_a, slt_a, res_a} !== want_a) begin
            n_fail++; $display("FAIL rand_rsp_a_%0d: got %b %h want %b %h", n, rsp_valid_a, {eq_a, slt_a, res_a}, exp_a, want_a); end
          n_checks++; if (rsp_valid_b !== exp_b || {eq_b, slt_b, res_b} !== want_b) begin
            n_fail++; $display("FAIL rand_rsp_b_%0d: got %b %h want %b %h", n, rsp_valid_b, {eq_b, slt_b, res_b}, exp_b, want_b); end
          if (j < d) tick();
        end
        req_valid = 2'b00; rsp_ready = 2'b11; tick(); rsp_ready = 2'b00;
        n_checks++; if (rsp_valid_a !== 2'b00 || rsp_valid_b !== 2'b00) begin
          n_fail++; $display("FAIL rand_release_%0d: got %b/%b want 00/00", n, rsp_valid_a, rsp_valid_b); end
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_ctrl = '0; req_op1 = '0; req_op2 = '0;
    test_reset();
    test_single();
    test_dual();
    test_fairness();
    test_hold();
    test_reset_exec();
    test_wrong_ready();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
